mips_seq_ctrl: RTL
==================

Name: mips_seq_ctrl

Overview:
Multi-cycle sequencer for the 8-bit-opcode MIPS-style core: fetches 32-bit instructions {opcode[31:24], dest[23:16], src1[15:8], src2[7:0]} and walks each one through FETCH/DECODE/EXEC/MEM/WB.
It drives the register-file, ALU, data-memory and stack strobes of the datapath, and owns the PC and stack pointer.
Instruction and data memories use req/ack handshakes so wait states are tolerated.

Parameters:
AW, 5, PC / memory address width (32-word memories)
DEPTH, 32, stack depth in words (sp range 0..DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enable; sampled only at instruction boundaries
imem_req  out  1  instruction fetch request
imem_addr  out  AW  fetch address (= pc)
imem_ack  in  1  fetch complete, imem_rdata valid
imem_rdata  in  32  instruction word
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store
dmem_addr  out  AW  data address
dmem_ack  in  1  data access complete
src_zero  in  1  datapath flag: registers[src2] == 0
ir  out  32  current instruction register
alu_op  out  2  0 add, 1 sub, 2 xor, 3 and
rf_we  out  1  register write strobe
rf_waddr  out  8  write register (= ir dest)
rf_wsel  out  2  0 ALU, 1 mem, 2 imm (src2 zero-extended), 3 stack
stk_push  out  1  push strobe (data = registers[src2])
stk_pop  out  1  pop strobe
sp  out  $clog2(DEPTH)+1  stack pointer
pc  out  AW  program counter
halt  out  1  core stopped
illegal  out  1  sticky: undefined opcode
stk_err  out  1  sticky: stack overflow or underflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, sp=0, ir=0. All strobes, req, halt, illegal and stk_err are 0 immediately.
- Outputs are Moore: decoded from state and ir only. No combinational input-to-output path.
- Opcodes: NOOP 0, LOAD 1, LDNM 2, STR 3, ADD 4, SUB 5, XOR 6, AND 7, JMP 8, JMP0 9, PUSH A, POP B. All others are illegal.
- IDLE: run=1 -> FETCH.
- FETCH: imem_req=1 with imem_addr=pc, held until imem_ack is sampled high at an edge. A zero-wait memory acks in the first req cycle.
  - On ack: ir<=imem_rdata, pc<=pc+1 (wraps modulo 2^AW), go to DECODE.
- DECODE, one cycle:
  - NOOP -> boundary.
  - JMP -> pc<=dest[AW-1:0], boundary.
  - JMP0 -> if src_zero=0 then pc<=dest[AW-1:0] (taken when register is nonzero), boundary.
  - ADD/SUB/XOR/AND, PUSH, POP -> EXEC.
  - LOAD, STR -> MEM.
  - LDNM -> WB.
  - Illegal -> HALT with illegal<=1.
- EXEC:
  - ALU ops: alu_op = opcode-4, -> WB.
  - PUSH: if sp==DEPTH, stk_err<=1 and -> HALT with no stk_push. Otherwise stk_push=1, sp<=sp+1, boundary.
  - POP: if sp==0, stk_err<=1 and -> HALT with no stk_pop. Otherwise stk_pop=1, sp<=sp-1, -> WB.
- MEM: dmem_req=1 held until dmem_ack.
  - LOAD: dmem_addr=src2[AW-1:0], dmem_we=0. On ack -> WB.
  - STR: dmem_addr=dest[AW-1:0], dmem_we=1. On ack -> boundary.
- WB: rf_we=1 for exactly one cycle, rf_waddr=dest. rf_wsel: ALU ops 0, LOAD 1, LDNM 2, POP 3. Then boundary.
- Boundary: run=1 -> FETCH, run=0 -> IDLE. run changes mid-instruction have no effect.
- HALT: halt=1, all strobes 0. Exited only by reset.
- Zero-wait cycle counts (FETCH through the last state):
  - NOOP, JMP, JMP0: 2 cycles.
  - LDNM, PUSH, STR: 3 cycles.
  - ALU, LOAD, POP: 4 cycles.
- Ack outside the matching req is ignored.
- Reset during a wait drops req immediately; the transaction is abandoned.

Test Plan:
- Reset, run=1, imem_rdata=0x020A0001, zero-wait -> imem_req with addr 0, then WB with rf_we=1, rf_waddr=0x0A, rf_wsel=2; pc=1; next FETCH 3 cycles after the first.
- ADD 0x04030102 -> EXEC alu_op=0, WB rf_we=1, rf_waddr=3, rf_wsel=0. SUB 0x05... -> alu_op=1. AND -> alu_op=3.
- JMP0 0x09060000 at pc=0: src_zero=0 -> pc=6; src_zero=1 -> pc=1. JMP 0x081F0000 -> pc=31, next fetch at 31 -> pc wraps to 0.
- STR 0x03010003 with dmem_ack after 3 wait cycles -> dmem_req=1, dmem_we=1, dmem_addr=1 held 4 cycles, no rf_we, then FETCH.
- 32 PUSHes -> sp=32 with 32 stk_push pulses; 33rd PUSH -> no pulse, stk_err=1, halt=1. Separately, POP at sp=0 -> stk_err=1, halt=1.
- Opcode 0x0C -> illegal=1, halt=1 after DECODE. rst_n low mid-MEM -> dmem_req=0 at once, state IDLE, pc=0, flags cleared.

Source files
------------

// File: rtl/mips_seq_ctrl.sv
// rtl/mips_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit-opcode core
// Owns pc, sp and ir; every output is decoded from registered state only.
module mips_seq_ctrl #(
   parameter int AW    = 5,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       run,
   output logic                       imem_req,
   output logic [AW-1:0]              imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_rdata,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [AW-1:0]              dmem_addr,
   input  logic                       dmem_ack,
   input  logic                       src_zero,
   output logic [31:0]                ir,
   output logic [1:0]                 alu_op,
   output logic                       rf_we,
   output logic [7:0]                 rf_waddr,
   output logic [1:0]                 rf_wsel,
   output logic                       stk_push,
   output logic                       stk_pop,
   output logic [$clog2(DEPTH):0]     sp,
   output logic [AW-1:0]              pc,
   output logic                       halt,
   output logic                       illegal,
   output logic                       stk_err
);
   localparam int SPW = $clog2(DEPTH) + 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   localparam logic [7:0] OP_NOOP = 8'h00, OP_LOAD = 8'h01, OP_LDNM = 8'h02, OP_STR  = 8'h03,
                          OP_ADD  = 8'h04, OP_SUB  = 8'h05, OP_XOR  = 8'h06, OP_AND  = 8'h07,
                          OP_JMP  = 8'h08, OP_JMP0 = 8'h09, OP_PUSH = 8'h0A, OP_POP  = 8'h0B;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [31:0]    ir_q, ir_d;
   logic           illegal_q, illegal_d;
   logic           stk_err_q, stk_err_d;

   logic [7:0] opc, dest, src2;
   logic       is_alu;
   state_t     bnd;

   assign opc    = ir_q[31:24];
   assign dest   = ir_q[23:16];
   assign src2   = ir_q[7:0];
   assign is_alu = (opc >= OP_ADD) && (opc <= OP_AND);
   assign bnd    = run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         sp_q      <= '0;
         ir_q      <= '0;
         illegal_q <= 1'b0;
         stk_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         sp_q      <= sp_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         stk_err_q <= stk_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      sp_d      = sp_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      stk_err_d = stk_err_q;
      case (state_q)
         S_IDLE:  if (run) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + AW'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opc)
               OP_NOOP: state_d = bnd;
               OP_JMP: begin
                  pc_d    = dest[AW-1:0];
                  state_d = bnd;
               end
               OP_JMP0: begin
                  // Branch is taken when the tested register is nonzero
                  if (!src_zero) pc_d = dest[AW-1:0];
                  state_d = bnd;
               end
               OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_PUSH, OP_POP: state_d = S_EXEC;
               OP_LOAD, OP_STR: state_d = S_MEM;
               OP_LDNM: state_d = S_WB;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_EXEC: begin
            if (opc == OP_PUSH) begin
               if (sp_q == SP_FULL) begin
                  stk_err_d = 1'b1;
                  state_d   = S_HALT;
               end else begin
                  sp_d    = sp_q + SPW'(1);
                  state_d = bnd;
               end
            end else if (opc == OP_POP) begin
               if (sp_q == '0) begin
                  stk_err_d = 1'b1;
                  state_d   = S_HALT;
               end else begin
                  sp_d    = sp_q - SPW'(1);
                  state_d = S_WB;
               end
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM:   if (dmem_ack) state_d = (opc == OP_STR) ? bnd : S_WB;
         S_WB:    state_d = bnd;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == S_FETCH);
      imem_addr = pc_q;
      dmem_req  = (state_q == S_MEM);
      dmem_we   = (state_q == S_MEM) && (opc == OP_STR);
      dmem_addr = (opc == OP_STR) ? dest[AW-1:0] : src2[AW-1:0];
      alu_op    = is_alu ? opc[1:0] : 2'd0;
      rf_we     = (state_q == S_WB);
      rf_waddr  = dest;
      case (opc)
         OP_LOAD: rf_wsel = 2'd1;
         OP_LDNM: rf_wsel = 2'd2;
         OP_POP:  rf_wsel = 2'd3;
         default: rf_wsel = 2'd0;
      endcase
      // Overflow/underflow cycles suppress the strobe; the error is flagged instead
      stk_push  = (state_q == S_EXEC) && (opc == OP_PUSH) && (sp_q != SP_FULL);
      stk_pop   = (state_q == S_EXEC) && (opc == OP_POP) && (sp_q != '0);
      halt      = (state_q == S_HALT);
   end

   assign ir      = ir_q;
   assign sp      = sp_q;
   assign pc      = pc_q;
   assign illegal = illegal_q;
   assign stk_err = stk_err_q;
endmodule
